// File: rtl/miriscv_pkg.sv
// Shared core definitions for the instruction prefetch path: data widths, the NOP
// encoding, the buffered entry layout and the prefetcher FSM states.
package miriscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [ILEN-1:0] RV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } pf_entry_t;

    typedef enum logic {
        PF_IDLE = 1'b0,
        PF_RUN  = 1'b1
    } pf_state_e;

endpackage

// File: rtl/miriscv_instr_prefetch_buffer_if.sv
// Bus bundle of the prefetcher: instruction-memory request/response side and the
// downstream instruction stream towards fetch.
interface miriscv_instr_prefetch_buffer_if;
    import miriscv_pkg::*;

    // Memory: a request is taken in every cycle instr_req_o is high (no stall); responses
    // come back in request order at least one cycle later. Stream: an instruction moves
    // downstream in exactly the cycles where pf_valid_o and pf_ready_i are both high.
    logic            instr_req_o;
    logic [XLEN-1:0] instr_addr_o;
    logic            instr_rvalid_i;
    logic [XLEN-1:0] instr_rdata_i;
    logic            pf_valid_o;
    logic [ILEN-1:0] pf_instr_o;
    logic [XLEN-1:0] pf_pc_o;
    logic            pf_ready_i;

    modport master (
        output instr_req_o, instr_addr_o,
        input  instr_rvalid_i, instr_rdata_i,
        output pf_valid_o, pf_instr_o, pf_pc_o,
        input  pf_ready_i
    );

    modport slave (
        input  instr_req_o, instr_addr_o,
        output instr_rvalid_i, instr_rdata_i,
        input  pf_valid_o, pf_instr_o, pf_pc_o,
        output pf_ready_i
    );

endinterface

// File: rtl/miriscv_sync_fifo.sv
// Synchronous FIFO of prefetch entries with registered storage; flush wins over
// push and pop, and a push into a full FIFO is taken only alongside a pop.
module miriscv_sync_fifo
    import miriscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   arstn_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  pf_entry_t              wdata_i,
    output pf_entry_t              rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    pf_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_en, pop_en;

    always_comb begin
        pop_en   = pop_i & ~flush_i & (cnt_q != '0);
        push_en  = push_i & ~flush_i & ((cnt_q != FULL_CNT) | pop_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({push_en, pop_en})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the top masks the head whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = cnt_q;
    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/miriscv_instr_prefetch_buffer.sv
// Sequential instruction prefetcher with redirect flush and stale-response discard.
// Optional same-cycle response bypass to the consumer: MIRISCV_PREFETCH_BYPASS_EN.
module miriscv_instr_prefetch_buffer
    import miriscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                             clk_i,
    input  logic                             arstn_i,
    input  logic [XLEN-1:0]                  boot_addr_i,
    input  logic                             cu_boot_addr_load_en_i,
    input  logic                             cu_kill_f_i,
    input  logic [XLEN-1:0]                  cu_pc_bra_i,
    miriscv_instr_prefetch_buffer_if.master  bus,
    output pf_state_e                        dbg_state_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     CAP     = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    pf_state_e       state_q, state_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   discard_q, discard_d;

    logic            running, redirect, issue;
    logic            resp_take, resp_keep, bypass_valid, bypass_take;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_cnt;
    logic [XLEN-1:0] target;
    pf_entry_t       fifo_head, fifo_wdata;

    always_comb begin
        running   = (state_q == PF_RUN);
        redirect  = cu_boot_addr_load_en_i | (running & cu_kill_f_i);
        target    = cu_boot_addr_load_en_i ? boot_addr_i : cu_pc_bra_i;
        issue     = running & ~redirect & (({1'b0, fifo_cnt} + {1'b0, outst_q}) < CAP);
        // Responses with nothing outstanding belong to requests cancelled by reset.
        resp_take = bus.instr_rvalid_i & (outst_q != '0);
        resp_keep = resp_take & (discard_q == '0) & ~redirect;
`ifdef MIRISCV_PREFETCH_BYPASS_EN
        bypass_valid = fifo_empty & resp_keep;
`else
        bypass_valid = 1'b0;
`endif
        bypass_take = bypass_valid & bus.pf_ready_i;
        fifo_push   = resp_keep & ~bypass_take;
        fifo_pop    = ~fifo_empty & bus.pf_ready_i & ~redirect;
        fifo_wdata  = '{instr: bus.instr_rdata_i, pc: resp_pc_q};

        bus.instr_req_o  = issue;
        bus.instr_addr_o = req_pc_q;
        bus.pf_valid_o   = ~fifo_empty | bypass_valid;
        if (!fifo_empty) begin
            bus.pf_instr_o = fifo_head.instr;
            bus.pf_pc_o    = fifo_head.pc;
        end else if (bypass_valid) begin
            bus.pf_instr_o = bus.instr_rdata_i;
            bus.pf_pc_o    = resp_pc_q;
        end else begin
            bus.pf_instr_o = RV_NOP;
            bus.pf_pc_o    = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_pc_d  = req_pc_q;
        resp_pc_d = resp_pc_q;
        discard_d = discard_q;
        outst_d   = outst_q;
        if (issue && !resp_take)      outst_d = outst_q + CNT_ONE;
        else if (!issue && resp_take) outst_d = outst_q - CNT_ONE;
        if (redirect) begin
            // Everything still in flight after this cycle answers the old stream.
            state_d   = PF_RUN;
            req_pc_d  = target;
            resp_pc_d = target;
            discard_d = outst_d;
        end else begin
            if (issue)     req_pc_d  = req_pc_q + PC_STEP;
            if (resp_keep) resp_pc_d = resp_pc_q + PC_STEP;
            if (resp_take && (discard_q != '0)) discard_d = discard_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arstn_i) begin
            state_q   <= PF_IDLE;
            req_pc_q  <= '0;
            resp_pc_q <= '0;
            outst_q   <= '0;
            discard_q <= '0;
        end else begin
            state_q   <= state_d;
            req_pc_q  <= req_pc_d;
            resp_pc_q <= resp_pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
        end
    end

    miriscv_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (redirect),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_head),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    no_overflow_a: assert property (@(posedge clk_i) disable iff (!arstn_i)
        !(fifo_push && fifo_full && !fifo_pop));

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_miriscv_instr_prefetch_buffer.sv
// Bench for the instruction prefetcher: in-order memory model with random latency,
// epoch-tagged request stream and an expected-PC queue for the instruction stream.
module tb_miriscv_instr_prefetch_buffer;
    import miriscv_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
        bit          counted;
    } mreq_t;

    logic            clk = 1'b0;
    logic            arstn = 1'b0;
    logic [XLEN-1:0] boot_addr = '0;
    logic [XLEN-1:0] pc_bra = '0;
    logic            boot_en = 1'b0;
    logic            kill = 1'b0;
    pf_state_e       dbg_state;

    miriscv_instr_prefetch_buffer_if bus();

    miriscv_instr_prefetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk_i                  (clk),
        .arstn_i                (arstn),
        .boot_addr_i            (boot_addr),
        .cu_boot_addr_load_en_i (boot_en),
        .cu_kill_f_i            (kill),
        .cu_pc_bra_i            (pc_bra),
        .bus                    (bus),
        .dbg_state_o            (dbg_state)
    );

    // Scoreboard and memory state.
    logic [31:0] exp_q[$];
    mreq_t       mem_q[$];
    logic [31:0] exp_req_addr = '0;
    int          epoch = 0, last_due = 0, cyc = 0;
    bit          run = 0;
    int          mem_lat = 1, mem_jit = 0, ready_mode = 0;

    // Observation counters, cleared by the stimulus between tests.
    int          n_checks = 0, n_fail = 0;
    int          pops = 0, issued = 0, bubbles = 0, stale_drops = 0, ignored = 0, byp_hits = 0;
    bit          track = 0, seen_valid = 0, first_seen = 0, req_seen = 0;
    logic [31:0] first_pc = '0, first_instr = '0, first_req_addr = '0;
    logic [31:0] req_log [3];
    logic [31:0] pc_log [3];
    int          req_log_n = 0, pc_log_n = 0;

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16]} + 32'h0101_0101;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory and consumer drivers, applied just after each rising edge.
    initial begin
        bus.instr_rvalid_i = 1'b0;
        bus.instr_rdata_i  = '0;
        bus.pf_ready_i     = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                bus.instr_rvalid_i = 1'b1;
                bus.instr_rdata_i  = mem_data(mem_q[0].addr);
            end else begin
                bus.instr_rvalid_i = 1'b0;
                bus.instr_rdata_i  = $urandom;
            end
            case (ready_mode)
                0:       bus.pf_ready_i = 1'b1;
                1:       bus.pf_ready_i = 1'b0;
                default: bus.pf_ready_i = ($urandom_range(0, 99) < 65);
            endcase
        end
    end

    task automatic note_pop();
        pops++;
        if (!first_seen) begin
            first_seen  = 1;
            first_pc    = bus.pf_pc_o;
            first_instr = bus.pf_instr_o;
        end
        if (pc_log_n < 3) begin
            pc_log[pc_log_n] = bus.pf_pc_o;
            pc_log_n++;
        end
    endtask

    // Reference model: one step per cycle, evaluated at the falling edge.
    task automatic model_step();
        bit          redir, resp, accept, exp_req, byp, exp_valid;
        logic [31:0] tgt, exp_pc;
        int          inflight, due;
        mreq_t       h;
        if (!arstn) begin
            foreach (mem_q[i]) mem_q[i].counted = 0;
            exp_q.delete();
            run = 0;
            if (bus.instr_rvalid_i && mem_q.size() > 0) begin
                void'(mem_q.pop_front());
                ignored++;
            end
            return;
        end
        redir    = boot_en || (run && kill);
        tgt      = boot_en ? boot_addr : pc_bra;
        inflight = 0;
        foreach (mem_q[i]) if (mem_q[i].counted) inflight++;
        resp     = bus.instr_rvalid_i && (mem_q.size() > 0);
        accept   = 0;
        h        = '{addr: '0, due: 0, epoch: 0, counted: 0};
        if (resp) begin
            h = mem_q.pop_front();
            accept = h.counted && (h.epoch == epoch) && !redir;
            if (!h.counted)  ignored++;
            else if (!accept) stale_drops++;
        end

        exp_req = run && !redir && (inflight + exp_q.size() < DEPTH);
        check_eq("instr_req", 32'(bus.instr_req_o), 32'(exp_req));
        if (bus.instr_req_o && exp_req) check_eq("instr_addr", bus.instr_addr_o, exp_req_addr);

        byp = 0;
`ifdef MIRISCV_PREFETCH_BYPASS_EN
        byp = (exp_q.size() == 0) && accept;
`endif
        exp_valid = (exp_q.size() > 0) || byp;
        exp_pc    = (exp_q.size() > 0) ? exp_q[0] : h.addr;
        check_eq("pf_valid", 32'(bus.pf_valid_o), 32'(exp_valid));
        if (exp_valid) begin
            check_eq("pf_pc", bus.pf_pc_o, exp_pc);
            check_eq("pf_instr", bus.pf_instr_o, mem_data(exp_pc));
        end else begin
            check_eq("pf_instr_nop", bus.pf_instr_o, RV_NOP);
        end
        if (track && seen_valid && !bus.pf_valid_o) bubbles++;
        if (bus.pf_valid_o) seen_valid = 1;

        if (redir) begin
            exp_q.delete();
            epoch++;
            exp_req_addr = tgt;
            run          = 1;
            first_seen   = 0;
            req_seen     = 0;
            req_log_n    = 0;
            pc_log_n     = 0;
        end else begin
            if (exp_valid && bus.pf_ready_i) begin
                note_pop();
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (byp) byp_hits++;
            end
            if (accept && !(byp && bus.pf_ready_i)) exp_q.push_back(h.addr);
        end

        if (bus.instr_req_o) begin
            due = cyc + mem_lat + $urandom_range(0, mem_jit);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{addr: bus.instr_addr_o, due: due, epoch: epoch, counted: 1});
            issued++;
            if (!req_seen) begin
                req_seen       = 1;
                first_req_addr = bus.instr_addr_o;
            end
            if (req_log_n < 3) begin
                req_log[req_log_n] = bus.instr_addr_o;
                req_log_n++;
            end
            exp_req_addr = exp_req_addr + 32'd4;
        end
    endtask

    always @(negedge clk) model_step();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_boot(input logic [31:0] a);
        boot_addr = a;
        boot_en   = 1'b1;
        tick();
        boot_en   = 1'b0;
        boot_addr = $urandom;
    endtask

    task automatic pulse_kill(input logic [31:0] a);
        pc_bra = a;
        kill   = 1'b1;
        tick();
        kill   = 1'b0;
    endtask

    initial begin
        arstn = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check_eq("rst_req", 32'(bus.instr_req_o), 32'd0);
        check_eq("rst_addr", bus.instr_addr_o, 32'd0);
        check_eq("rst_valid", 32'(bus.pf_valid_o), 32'd0);
        check_eq("rst_instr", bus.pf_instr_o, RV_NOP);
        check_eq("rst_pc", bus.pf_pc_o, 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'(PF_IDLE));
        tick();
        arstn = 1'b1;

        // Kill while idle must not start fetching.
        issued = 0;
        pulse_kill(32'h0000_0300);
        repeat (3) tick();
        check_eq("idle_kill_reqs", 32'(issued), 32'd0);

        // Boot, latency 1, always ready: back-to-back stream.
        ready_mode = 0; mem_lat = 1; mem_jit = 0;
        pops = 0; bubbles = 0; seen_valid = 0; track = 1;
        pulse_boot(32'h8000_0000);
        repeat (30) tick();
        track = 0;
        check_eq("t1_bubbles", 32'(bubbles), 32'd0);
        check_eq("t1_pops_ge25", 32'(pops >= 25), 32'd1);
        check_eq("t1_state", 32'(dbg_state), 32'(PF_RUN));
        check_eq("t1_req0", req_log[0], 32'h8000_0000);
        check_eq("t1_req1", req_log[1], 32'h8000_0004);
        check_eq("t1_req2", req_log[2], 32'h8000_0008);
        check_eq("t1_pc0", pc_log[0], 32'h8000_0000);
        check_eq("t1_pc2", pc_log[2], 32'h8000_0008);

        // Consumer stalled: the issue cap stops requests at DEPTH.
        ready_mode = 1; issued = 0;
        pulse_boot(32'h0000_1000);
        repeat (10) tick();
        check_eq("t2_issued", 32'(issued), 32'(DEPTH));
        check_eq("t2_req_low", 32'(bus.instr_req_o), 32'd0);
        check_eq("t2_valid", 32'(bus.pf_valid_o), 32'd1);
        check_eq("t2_head_pc", bus.pf_pc_o, 32'h0000_1000);
        ready_mode = 0; pops = 0;
        repeat (12) tick();
        check_eq("t2_pops_ge10", 32'(pops >= 10), 32'd1);
        check_eq("t2_resumed", 32'(issued > DEPTH), 32'd1);

        // Latency 3, two in flight, kill to 0x100.
        mem_lat = 3;
        pulse_boot(32'h0000_4000);
        stale_drops = 0;
        tick(); tick();
        pulse_kill(32'h0000_0100);
        repeat (12) tick();
        check_eq("t3_stale", 32'(stale_drops), 32'd2);
        check_eq("t3_first_req", first_req_addr, 32'h0000_0100);
        check_eq("t3_first_pc", first_pc, 32'h0000_0100);
        check_eq("t3_first_instr", first_instr, mem_data(32'h0000_0100));

        // Boot load and kill together: boot wins.
        mem_lat = 1;
        pc_bra = 32'h0000_0200; boot_addr = 32'h8000_0000;
        boot_en = 1'b1; kill = 1'b1;
        tick();
        boot_en = 1'b0; kill = 1'b0;
        repeat (8) tick();
        check_eq("t4_first_req", first_req_addr, 32'h8000_0000);
        check_eq("t4_first_pc", first_pc, 32'h8000_0000);

        // Address wrap at the top of the address space.
        pulse_boot(32'hFFFF_FFF8);
        repeat (10) tick();
        check_eq("t5_req0", req_log[0], 32'hFFFF_FFF8);
        check_eq("t5_req1", req_log[1], 32'hFFFF_FFFC);
        check_eq("t5_req2", req_log[2], 32'h0000_0000);
        check_eq("t5_pc0", pc_log[0], 32'hFFFF_FFF8);
        check_eq("t5_pc1", pc_log[1], 32'hFFFF_FFFC);
        check_eq("t5_pc2", pc_log[2], 32'h0000_0000);

        // Reset with three requests in flight; late responses are ignored.
        mem_lat = 5;
        pulse_boot(32'h0000_2000);
        tick(); tick(); tick();
        ignored = 0;
        arstn = 1'b0;
        tick();
        arstn = 1'b1;
        repeat (10) tick();
        check_eq("t6_ignored", 32'(ignored), 32'd3);
        check_eq("t6_valid", 32'(bus.pf_valid_o), 32'd0);
        check_eq("t6_state", 32'(dbg_state), 32'(PF_IDLE));

        // Random traffic: random latency, random consumer, random redirects.
        ready_mode = 2; pops = 0; byp_hits = 0;
        pulse_boot(32'h0001_0000);
        for (int i = 0; i < 600; i++) begin
            int r;
            if (i % 60 == 0) begin
                mem_lat = $urandom_range(1, 3);
                mem_jit = $urandom_range(0, 2);
            end
            r = $urandom_range(0, 99);
            if (r < 3)      pulse_kill($urandom & 32'hFFFF_FFFC);
            else if (r < 4) pulse_boot($urandom & 32'hFFFF_FFFC);
            else            tick();
        end
        check_eq("t7_pops_ge100", 32'(pops >= 100), 32'd1);
`ifdef MIRISCV_PREFETCH_BYPASS_EN
        check_eq("t7_bypass_used", 32'(byp_hits > 0), 32'd1);
`endif
        ready_mode = 0;
        repeat (20) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
